// File: rtl/tone_meter_pkg.sv
// Shared constants and FSM encoding for the tone meter.
// Default gate is 100 ms of the 25 MHz design clock.
package tone_meter_pkg;

  localparam int CLK_HZ           = 25_000_000;
  localparam int DEFAULT_GATE_LEN = CLK_HZ / 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus registered edge detect for the audio line.
// level/rise/fall appear 3 clk after the pin moves; no backpressure.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;

  // level is the previous synchronized sample, so it lines up with the pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      meta  <= din;
      sync  <= meta;
      level <= sync;
      rise  <= sync & ~level;
      fall  <= ~sync & level;
    end
  end

endmodule

// File: rtl/tone_meter.sv
// Gated rising-edge count, last period and last high time of a 1-bit audio line.
// Results land one clk after the synchronized edge or gate end; no backpressure, valid is a 1-cycle strobe.
module tone_meter
  import tone_meter_pkg::*;
#(
  parameter int GATE_LEN = DEFAULT_GATE_LEN,
  parameter int CNT_W    = 16,
  parameter int PER_W    = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             audio_in,
  output logic [CNT_W-1:0] freq_count,
  output logic [PER_W-1:0] period,
  output logic [PER_W-1:0] high_time,
  output logic             valid,
  output logic             silent,
  output logic             overflow
);

  localparam int GATE_W = $clog2(GATE_LEN);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [PER_W-1:0]  PER_MAX   = '1;
  localparam logic [PER_W-1:0]  PER_ONE   = PER_W'(1);
  localparam logic [PER_W-1:0]  PER_PRE   = PER_MAX - PER_ONE;

  state_t            state;
  state_t            state_nxt;
  logic              lvl;
  logic              rise;
  logic              fall;
  logic              running;
  logic              measuring;
  logic              gate_end;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              edge_sat;
  logic [PER_W-1:0]  per_cnt;
  logic [PER_W-1:0]  high_cnt;

  edge_sync u_edge_sync (
    .clk   (clk),
    .reset (reset),
    .din   (audio_in),
    .level (lvl),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    running   = 1'b0;
    measuring = 1'b0;
    gate_end  = 1'b0;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_ARM;
        ST_ARM: begin
          running = 1'b1;
          if (rise) state_nxt = ST_MEAS;
        end
        ST_MEAS: begin
          running   = 1'b1;
          measuring = 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
      gate_end = running && (gate_cnt == GATE_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      edge_sat   <= 1'b0;
      per_cnt    <= '0;
      high_cnt   <= '0;
      freq_count <= '0;
      period     <= '0;
      high_time  <= '0;
      valid      <= 1'b0;
      silent     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!running) begin
        // idle or disabled: a partial gate is dropped, published results hold
        gate_cnt <= '0;
        edge_cnt <= '0;
        edge_sat <= 1'b0;
        per_cnt  <= '0;
        high_cnt <= '0;
      end else begin
        gate_cnt <= gate_end ? '0 : gate_cnt + 1'b1;
        if (gate_end) begin
          freq_count <= edge_cnt;
          overflow   <= edge_sat;
          valid      <= 1'b1;
          edge_cnt   <= CNT_W'(rise);
          edge_sat   <= 1'b0;
        end else if (rise) begin
          if (edge_cnt == CNT_MAX) edge_sat <= 1'b1;
          else                     edge_cnt <= edge_cnt + 1'b1;
        end

        if (rise) begin
          per_cnt  <= PER_ONE;
          high_cnt <= PER_ONE;
          if (measuring) begin
            period <= per_cnt;
            silent <= 1'b0;
          end
        end else if (measuring) begin
          // the period counter parks at its maximum; silence is flagged once on arrival
          if (per_cnt == PER_PRE) begin
            per_cnt <= PER_MAX;
            silent  <= 1'b1;
            period  <= '0;
          end else if (per_cnt != PER_MAX) begin
            per_cnt <= per_cnt + PER_ONE;
          end
          if (fall) high_time <= high_cnt;
          if (!lvl)                   high_cnt <= '0;
          else if (high_cnt != PER_MAX) high_cnt <= high_cnt + PER_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_tone_meter.sv
// Randomized bench for tone_meter against an event-time reference model.
module tb_tone_meter;

  localparam int L    = 200;
  localparam int CW   = 4;
  localparam int PW   = 8;
  localparam int CMAX = (1 << CW) - 1;
  localparam int PMAX = (1 << PW) - 1;
  localparam int OW   = 1 + CW + 1 + PW + PW + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          audio_in = 1'b0;
  logic [CW-1:0] freq_count;
  logic [PW-1:0] period;
  logic [PW-1:0] high_time;
  logic          valid;
  logic          silent;
  logic          overflow;

  tone_meter #(.GATE_LEN(L), .CNT_W(CW), .PER_W(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .audio_in   (audio_in),
    .freq_count (freq_count),
    .period     (period),
    .high_time  (high_time),
    .valid      (valid),
    .silent     (silent),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  logic [OW-1:0] obs;
  assign obs = {valid, freq_count, overflow, period, high_time, silent};

  int n_tests = 0;
  int n_fail  = 0;

  // requested pin / enable / reset levels, applied by tick() at the falling edge
  logic aud = 1'b0;
  logic en = 1'b0;
  logic rst_drv = 1'b0;

  // reference model: synchronized edges as (cycle, is_rise) events
  typedef struct { int t; logic r; } ev_t;
  ev_t evq[$];
  int  cyc = 0;
  logic m_en_p, m_act, m_armed;
  int  m_a, m_cnt, m_last_rise, m_rise_t;
  int  e_freq, e_per, e_high;
  logic e_valid, e_silent, e_over;

  function automatic int sat(int v, int m);
    return (v > m) ? m : v;
  endfunction

  function automatic logic wave_bit(int i, int hi, int per);
    return (i % per) < hi;
  endfunction

  function automatic logic [OW-1:0] exp_vec();
    return {e_valid, CW'(e_freq), e_over, PW'(e_per), PW'(e_high), e_silent};
  endfunction

  function automatic void model_reset();
    evq.delete();
    m_en_p = 1'b0; m_act = 1'b0; m_armed = 1'b0;
    m_a = 0; m_cnt = 0; m_last_rise = 0; m_rise_t = 0;
    e_freq = 0; e_per = 0; e_high = 0;
    e_valid = 1'b0; e_silent = 1'b0; e_over = 1'b0;
  endfunction

  // What cycle p does to the published results (visible from cycle p+1).
  function automatic void model_cycle(int p);
    logic r, f;
    r = 1'b0;
    f = 1'b0;
    while (evq.size() > 0 && evq[0].t <= p) begin
      if (evq[0].t == p) begin
        if (evq[0].r) r = 1'b1;
        else          f = 1'b1;
      end
      void'(evq.pop_front());
    end
    e_valid = 1'b0;
    if (!m_en_p) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      m_act = 1'b1; m_a = p + 1; m_armed = 1'b0; m_cnt = 0;
    end else begin
      if ((p - m_a) % L == L - 1) begin
        e_freq = sat(m_cnt, CMAX); e_over = (m_cnt > CMAX); e_valid = 1'b1; m_cnt = 0;
      end
      if (r) m_cnt++;
      if (!m_armed) begin
        if (r) begin m_armed = 1'b1; m_last_rise = p; m_rise_t = p; end
      end else begin
        if (r) begin
          e_per = sat(p - m_last_rise, PMAX); e_silent = 1'b0;
          m_last_rise = p; m_rise_t = p;
        end else if (p - m_last_rise == PMAX - 1) begin
          e_silent = 1'b1; e_per = 0;
        end
        if (f) e_high = sat(p - m_rise_t, PMAX);
      end
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
    model_cycle(cyc - 1);
    m_en_p = en;
    enable = en;
    reset  = rst_drv;
    if (aud !== audio_in) evq.push_back('{cyc + 3, aud});
    audio_in = aud;
  endtask

  task automatic test_reset();
    rst_drv = 1'b0; en = 1'b0; aud = 1'b0;
    repeat (4) tick();
    n_tests++; if (freq_count !== '0) begin n_fail++; $display("FAIL reset_freq got %0d want 0", freq_count); end
    n_tests++; if (period !== '0) begin n_fail++; $display("FAIL reset_period got %0d want 0", period); end
    n_tests++; if (high_time !== '0) begin n_fail++; $display("FAIL reset_high got %0d want 0", high_time); end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
    n_tests++; if (silent !== 1'b0) begin n_fail++; $display("FAIL reset_silent got %b want 0", silent); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    rst_drv = 1'b1;
    tick();
  endtask

  task automatic test_square();
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int per, hi;
      per = 2 * $urandom_range(10, 40);
      hi  = per / 2;
      for (int i = 0; i < 1000; i++) begin
        aud = wave_bit(i, hi, per);
        tick();
        n_tests++;
        if (obs !== exp_vec()) begin
          n_fail++; $display("FAIL square cyc=%0d got {v,f,o,p,h,s}=%h want %h", cyc, obs, exp_vec());
        end
      end
      n_tests++;
      if (period !== PW'(per) || high_time !== PW'(hi)) begin
        n_fail++; $display("FAIL square_meas got p=%0d h=%0d want p=%0d h=%0d", period, high_time, per, hi);
      end
    end
  endtask

  task automatic test_duty();
    int hi, lo, ph;
    hi = $urandom_range(1, 40); lo = $urandom_range(1, 40); ph = 0;
    en = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      aud = (ph < hi);
      tick();
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL duty cyc=%0d got {v,f,o,p,h,s}=%h want %h", cyc, obs, exp_vec());
      end
      ph++;
      if (ph == hi + lo) begin
        ph = 0; hi = $urandom_range(1, 40); lo = $urandom_range(1, 40);
      end
    end
  endtask

  task automatic test_gate_edge();
    int a, base, idx, nvalid;
    en = 1'b0; aud = 1'b0;
    repeat (3) tick();
    en = 1'b1;
    tick();
    a = cyc + 1;
    base = a + L - 4;   // pin rises land on the gate-end cycle after the 3-clk synchronizer
    nvalid = 0;
    for (int i = 0; i < 1400; i++) begin
      idx = cyc + 1;
      aud = ((((idx - base) % 100) + 100) % 100) < 50;
      tick();
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL gate_edge cyc=%0d got {v,f,o,p,h,s}=%h want %h", cyc, obs, exp_vec());
      end
      if (valid === 1'b1) nvalid++;
      if (valid === 1'b1 && cyc > a + L) begin
        n_tests++;
        if (freq_count !== CW'(2)) begin n_fail++; $display("FAIL gate_edge_freq got %0d want 2", freq_count); end
      end
    end
    n_tests++;
    if (nvalid != 1399 / L) begin n_fail++; $display("FAIL gate_edge_pulses got %0d want %0d", nvalid, 1399 / L); end
  endtask

  task automatic test_overflow();
    int nv;
    en = 1'b1; nv = 0;
    for (int i = 0; i < 800; i++) begin
      aud = wave_bit(i, 5, 10);
      tick();
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL ovf_fast cyc=%0d got {v,f,o,p,h,s}=%h want %h", cyc, obs, exp_vec());
      end
      if (valid === 1'b1) begin
        nv++;
        if (nv >= 2) begin
          n_tests++;
          if (freq_count !== CW'(CMAX) || overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_set got f=%0d o=%b want f=%0d o=1", freq_count, overflow, CMAX);
          end
        end
      end
    end
    nv = 0;
    for (int i = 0; i < 1000; i++) begin
      aud = wave_bit(i, 25, 50);
      tick();
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL ovf_slow cyc=%0d got {v,f,o,p,h,s}=%h want %h", cyc, obs, exp_vec());
      end
      if (valid === 1'b1) begin
        nv++;
        if (nv >= 3) begin
          n_tests++;
          if (freq_count !== CW'(4) || overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear got f=%0d o=%b want f=4 o=0", freq_count, overflow);
          end
        end
      end
    end
  endtask

  task automatic test_silent();
    en = 1'b1;
    for (int i = 0; i < 420; i++) begin
      aud = (i < 120) ? wave_bit(i, 10, 20) : 1'b0;
      tick();
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL silent cyc=%0d got {v,f,o,p,h,s}=%h want %h", cyc, obs, exp_vec());
      end
    end
    n_tests++;
    if (silent !== 1'b1 || period !== '0) begin
      n_fail++; $display("FAIL silent_set got s=%b p=%0d want s=1 p=0", silent, period);
    end
    aud = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL silent_wake cyc=%0d got {v,f,o,p,h,s}=%h want %h", cyc, obs, exp_vec());
      end
    end
    n_tests++;
    if (silent !== 1'b0 || period !== PW'(PMAX)) begin
      n_fail++; $display("FAIL silent_clear got s=%b p=%0d want s=0 p=%0d", silent, period, PMAX);
    end
  endtask

  task automatic test_enable();
    int nv;
    en = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      aud = wave_bit(i, 15, 40);
      if (i == 300) begin en = 1'b0; nv = 0; end
      if (i == 380) begin
        n_tests++;
        if (nv != 0) begin n_fail++; $display("FAIL enable_novalid got %0d pulses want 0", nv); end
        en = 1'b1;
      end
      tick();
      if (i > 300 && valid === 1'b1) nv++;
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL enable cyc=%0d got {v,f,o,p,h,s}=%h want %h", cyc, obs, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1;
    for (int i = 0; i < 330; i++) begin
      aud = wave_bit(i, 12, 30);
      tick();
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL pre_reset cyc=%0d got {v,f,o,p,h,s}=%h want %h", cyc, obs, exp_vec());
      end
    end
    #1 reset = 1'b0;
    #1;
    n_tests++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_mid got {v,f,o,p,h,s}=%h want 0", obs); end
    model_reset();
    rst_drv = 1'b0; en = 1'b0; aud = 1'b0;
    repeat (4) tick();
    rst_drv = 1'b1; en = 1'b1;
    for (int i = 0; i < 500; i++) begin
      aud = wave_bit(i, 12, 30);
      tick();
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL post_reset cyc=%0d got {v,f,o,p,h,s}=%h want %h", cyc, obs, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_square();
    test_duty();
    test_gate_edge();
    test_overflow();
    test_silent();
    test_enable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
